// File: rtl/data_mem_responder_if.sv
// Data-port bundle between the core (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int SB_DEPTH = 4
);
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic [31:0]   a;
    logic          we;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          stall;
    logic [CW-1:0] sb_count;
    logic          busy;

    modport master (output a, we, wd, input rd, stall, sb_count, busy);
    modport slave  (input a, we, wd, output rd, stall, sb_count, busy);
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a posted-write store buffer that drains one entry
// every WR_LATENCY edges; reads forward from the newest matching buffered write.
module data_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int SB_DEPTH   = 4,
    parameter int WR_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam int LW = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [31:0]   mem_reg     [DEPTH];
    logic [AW-1:0] sb_idx_reg  [SB_DEPTH];
    logic [31:0]   sb_data_reg [SB_DEPTH];
    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic [LW-1:0] wait_cnt_reg;
    logic [0:0]    state_reg, state_next;

    logic [AW-1:0]       a_idx;
    logic                stall, push, pop;
    logic [SB_DEPTH-1:0] slot_hit;
    logic [PW-1:0]       slot;
    logic [31:0]         rd_val;

    assign a_idx = bus.a[AW+1:2];
    // Stall is purely occupancy-based, so a pop on the same edge does not admit a write.
    assign stall = (count_reg == CW'(SB_DEPTH));
    assign push  = bus.we && !stall;
    assign pop   = (state_reg == ST_DRAIN) && (wait_cnt_reg == LW'(WR_LATENCY - 1));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SB_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (push) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && count_reg == CW'(1) && !push) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            wait_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
        end else begin
            state_reg <= state_next;
            if (push) tail_reg <= ptr_inc(tail_reg);
            if (pop)  head_reg <= ptr_inc(head_reg);
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (state_reg == ST_DRAIN)
                wait_cnt_reg <= pop ? '0 : wait_cnt_reg + LW'(1);
            else
                wait_cnt_reg <= '0;
        end
    end

    // Entry payloads need no reset; validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_idx_reg[tail_reg]  <= a_idx;
            sb_data_reg[tail_reg] <= bus.wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (pop) begin
            mem_reg[sb_idx_reg[head_reg]] <= sb_data_reg[head_reg];
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
        assign slot_hit[gi] =
            (((gi + SB_DEPTH - int'(head_reg)) % SB_DEPTH) < int'(count_reg)) &&
            (sb_idx_reg[gi] == a_idx);
    end

    // Walk oldest to newest so the youngest matching entry wins.
    always_comb begin
        rd_val = mem_reg[a_idx];
        slot   = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = PW'((int'(head_reg) + k) % SB_DEPTH);
            if (slot_hit[slot]) rd_val = sb_data_reg[slot];
        end
    end

    assign bus.rd       = rd_val;
    assign bus.stall    = stall;
    assign bus.sb_count = count_reg;
    assign bus.busy     = (state_reg == ST_DRAIN);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a commit-time queue model.
module tb_data_mem_responder;
    localparam int DEPTH      = 256;
    localparam int SB_DEPTH   = 4;
    localparam int WR_LATENCY = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if #(.SB_DEPTH(SB_DEPTH)) bus ();

    data_mem_responder #(.DEPTH(DEPTH), .SB_DEPTH(SB_DEPTH), .WR_LATENCY(WR_LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Each pending write carries the edge number on which it lands in the array.
    typedef struct {
        int          idx;
        logic [31:0] data;
        int          commit;
    } wr_t;

    wr_t         q[$];
    logic [31:0] ref_mem [DEPTH];
    int          edge_n = 0;
    int          tests  = 0;
    int          fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].idx == idx_of(a)) return q[i].data;
        return ref_mem[idx_of(a)];
    endfunction

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd);
        bus.a  = a;
        bus.we = we;
        bus.wd = wd;
    endtask

    // Advance the model by one edge using the inputs now on the bus, then clock the DUT.
    task automatic tick();
        bit full;
        int c;
        full = (q.size() == SB_DEPTH);
        edge_n++;
        if (q.size() > 0 && q[0].commit == edge_n) begin
            ref_mem[q[0].idx] = q[0].data;
            void'(q.pop_front());
        end
        if (bus.we && !full) begin
            c = ((q.size() > 0) ? q[$].commit : edge_n) + WR_LATENCY;
            q.push_back('{idx: idx_of(bus.a), data: bus.wd, commit: c});
            $display("[TB] edge %0d write a=%h d=%h commit@%0d", edge_n, bus.a, bus.wd, c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".stall"}, 32'(bus.stall), 32'(q.size() == SB_DEPTH));
        check({tag, ".count"}, 32'(bus.sb_count), 32'(q.size()));
        check({tag, ".busy"}, 32'(bus.busy), 32'(q.size() != 0));
        check({tag, ".rd"}, bus.rd, ref_rd(bus.a));
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.a = a;
        #1;
        check(tag, bus.rd, exp);
        check({tag, ".model"}, bus.rd, ref_rd(a));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset = 1'b0;
        $display("[TB] edge %0d reset", edge_n);
    endtask

    initial begin
        int waits;
        bit acc;
        logic [31:0] ra;
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        #12;
        reset = 1'b0;

        // 1: reset state
        read_chk("t1.rd", 32'h40, 32'h0);
        check_state("t1");

        // 2: single write, forwarded then committed
        drive(32'h40, 1'b1, 32'hDEADBEEF);
        tick();
        bus.we = 1'b0;
        check_state("t2.push");
        check("t2.fwd", bus.rd, 32'hDEADBEEF);
        check("t2.count1", 32'(bus.sb_count), 32'd1);
        for (int i = 0; i < WR_LATENCY; i++) begin
            tick();
            check_state("t2.drain");
        end
        check("t2.count0", 32'(bus.sb_count), 32'd0);
        check("t2.busy0", 32'(bus.busy), 32'd0);
        check("t2.rd", bus.rd, 32'hDEADBEEF);

        // 3: duplicate address, newest value always visible
        drive(32'h08, 1'b1, 32'h11);
        tick();
        drive(32'h08, 1'b1, 32'h22);
        tick();
        bus.we = 1'b0;
        for (int i = 0; i < 2 * WR_LATENCY; i++) begin
            check("t3.rd22", bus.rd, 32'h22);
            check_state("t3");
            tick();
        end
        check("t3.rd_end", bus.rd, 32'h22);
        check("t3.empty", 32'(bus.sb_count), 32'd0);

        // 4: fill the buffer, hold the fifth write through stall
        for (int i = 0; i < 5; i++) begin
            drive(32'(i * 4), 1'b1, 32'(i + 1));
            waits = 0;
            acc   = 1'b0;
            while (!acc && waits < 40) begin
                acc = (q.size() < SB_DEPTH);
                tick();
                check_state("t4");
                if (!acc) waits++;
            end
            if (!acc) check("t4.timeout", 32'd0, 32'd1);
            if (i == 3) begin
                check("t4.stall_full", 32'(bus.stall), 32'd1);
                check("t4.count_full", 32'(bus.sb_count), 32'd4);
            end
            if (i == 4) check("t4.stall_waits", 32'(waits), 32'd1);
        end
        bus.we = 1'b0;
        for (int i = 0; i < 5 * WR_LATENCY; i++) begin
            tick();
            check_state("t4.drain");
        end
        check("t4.idle", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 5; i++) read_chk("t4.rb", 32'(i * 4), 32'(i + 1));

        // 5: reset discards pending writes mid-drain
        drive(32'h20, 1'b1, 32'h1111);
        tick();
        drive(32'h24, 1'b1, 32'h2222);
        tick();
        drive(32'h28, 1'b1, 32'h3333);
        tick();
        bus.we = 1'b0;
        tick();
        tick();
        do_reset();
        read_chk("t5.rd20", 32'h20, 32'h0);
        read_chk("t5.rd24", 32'h24, 32'h0);
        read_chk("t5.rd28", 32'h28, 32'h0);
        check_state("t5");

        // 6: upper address bits and byte offset ignored
        drive(32'h400, 1'b1, 32'hA5);
        tick();
        bus.we = 1'b0;
        read_chk("t6.alias", 32'h000, 32'hA5);
        drive(32'h40, 1'b1, 32'h7);
        tick();
        bus.we = 1'b0;
        read_chk("t6.byteoff", 32'h43, 32'h7);
        for (int i = 0; i < 3 * WR_LATENCY; i++) begin
            tick();
            check_state("t6.drain");
        end
        read_chk("t6.alias_c", 32'hFFFF_FC00, 32'hA5);

        // Random traffic over a small index range so forwarding collisions are common
        for (int n = 0; n < 400; n++) begin
            ra      = $urandom;
            ra[9:2] = 8'($urandom_range(0, 7));
            drive(ra, ($urandom_range(0, 99) < 45), $urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            tick();
            check_state("rnd");
        end
        bus.we = 1'b0;
        for (int i = 0; i < SB_DEPTH * WR_LATENCY + 2; i++) begin
            tick();
            check_state("rnd.drain");
        end
        for (int i = 0; i < 8; i++) read_chk("rnd.final", 32'(i * 4), ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
